regex_cmd_queue: RTL
====================

REGEX_CMD_QUEUE -- requirements
Module: regex_cmd_queue

Interface
REQ-001 SHALL have parameter PMEM_ADDR_WIDTH, default 8: width of scan start address.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of scan length.
REQ-003 SHALL have parameter TAG_WIDTH, default 8: width of software command tag.
REQ-004 SHALL have parameter DEPTH, default 4, power of two >= 2: entries in each of the command FIFO and the result FIFO.
REQ-005 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports: in_addr  in  PMEM_ADDR_WIDTH, in_len  in  LEN_WIDTH, in_tag  in  TAG_WIDTH, in_valid  in  1, in_ready  out  1: command push from the core IO register stage.
REQ-008 SHALL have ports: cmd_addr  out  PMEM_ADDR_WIDTH, cmd_len  out  LEN_WIDTH, cmd_valid  out  1, cmd_ready  in  1: command to the regex engine.
REQ-009 SHALL have ports: status_done  in  1 (one-cycle pulse per finished scan), status_match  in  1 (valid with status_done).
REQ-010 SHALL have ports: res_tag  out  TAG_WIDTH, res_match  out  1, res_valid  out  1, res_ready  in  1: result pop.
REQ-011 SHALL have ports: cmd_count  out  $clog2(DEPTH)+1, res_count  out  $clog2(DEPTH)+1, done_count  out  32, error  out  1, error_ack  in  1.

Function
REQ-012 SHALL accept a command on a rising edge where in_valid && in_ready; in_ready = (cmd_count < DEPTH), combinational from registered state.
REQ-013 SHALL run FSM states IDLE, ISSUE, WAIT.
REQ-014 IDLE -> ISSUE SHALL occur when the command FIFO is non-empty, the head has in_len != 0, and res_count + 0 < DEPTH (a result slot is free); head is popped on this edge and latched into cmd_addr/cmd_len/tag register.
REQ-015 In ISSUE, cmd_valid SHALL be 1 and cmd_addr/cmd_len SHALL be stable until cmd_valid && cmd_ready; then -> WAIT, cmd_valid 0 next cycle.
REQ-016 In WAIT, on status_done SHALL push {latched tag, status_match} into the result FIFO and -> IDLE; at most one scan outstanding.
REQ-017 A head command with len 0 in IDLE with a free result slot SHALL be popped and pushed as {tag, match=0} in one edge without asserting cmd_valid; FSM stays IDLE.
REQ-018 Command accepted on edge N into empty queue with FSM IDLE SHALL produce cmd_valid high after edge N+2 (one cycle for FIFO visibility, one for issue register).
REQ-019 res_valid SHALL equal (res_count != 0); res_tag/res_match SHALL show the oldest entry; pop on res_valid && res_ready.
REQ-020 Simultaneous push and pop on either FIFO SHALL leave its count unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-021 A push to the command FIFO while in_ready = 0 SHALL be ignored (no overwrite).
REQ-022 done_count SHALL increment by 1 on every result push (including zero-length), wrapping 0xFFFFFFFF -> 0.
REQ-023 status_done while FSM is IDLE or ISSUE SHALL set error (sticky) and SHALL NOT push a result.
REQ-024 error_ack high SHALL clear error on the next edge; a new error event in the same cycle SHALL win (error stays 1).

Reset
REQ-025 With rst_n low on a rising edge: FSM = IDLE, both FIFOs empty, cmd_count = res_count = 0, done_count = 0, cmd_valid = 0, res_valid = 0, error = 0; in_ready = 1 the cycle after.
REQ-026 Reset mid-scan (ISSUE or WAIT) SHALL drop the outstanding command; a later status_done from the engine SHALL set error.
REQ-027 FIFO data storage need not be reset; only pointers and counts.

Verification
REQ-028 Push {addr=0x10,len=64,tag=0x5A}; cmd_ready=1; status_done+match=1 three cycles later -> cmd_valid high at N+2 with addr 0x10 len 64; result {0x5A,1}; done_count=1.
REQ-029 Push 5 commands with cmd_ready=0, DEPTH=4 -> first issued, in_ready drops only when cmd_count=4; fifth accepted only after a pop; issue order = push order.
REQ-030 Fill result FIFO (res_ready=0, 4 results) -> no further cmd_valid while res_count=4; one pop -> next command issued.
REQ-031 Push len=0 tag=0x03 -> result {0x03,0} without cmd_valid ever asserting; done_count increments.
REQ-032 status_done pulse while IDLE -> error=1, no result; error_ack -> error=0; simultaneous second stray done with error_ack -> error stays 1.
REQ-033 Reset asserted in WAIT -> all counts 0, cmd_valid 0; subsequent status_done -> error=1.

Source files
------------

// File: rtl/regex_cmd_queue.sv
// regex_cmd_queue
//
// Queues scan commands from the core IO register stage and hands them to the
// regex engine one at a time. It collects each scan's match result, tagged
// with the software tag, into a result FIFO for software to pop. Zero-length
// commands never reach the engine: they complete immediately with match=0.
//
// Ports
//   clk, rst_n            : single clock, synchronous active-low reset
//   in_addr/len/tag       : command push (valid/ready)
//   in_valid, in_ready
//   cmd_addr/len          : command to the regex engine (valid/ready)
//   cmd_valid, cmd_ready
//   status_done/match     : engine completion pulse and its match flag
//   res_tag/match         : oldest result (valid/ready pop)
//   res_valid, res_ready
//   cmd_count, res_count  : FIFO occupancies
//   done_count            : free-running count of results produced
//   error, error_ack      : sticky flag for status_done with no scan in flight

module regex_cmd_queue #(
  parameter int PMEM_ADDR_WIDTH = 8,
  parameter int LEN_WIDTH       = 16,
  parameter int TAG_WIDTH       = 8,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PMEM_ADDR_WIDTH-1:0] in_addr,
  input  logic [LEN_WIDTH-1:0]       in_len,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PMEM_ADDR_WIDTH-1:0] cmd_addr,
  output logic [LEN_WIDTH-1:0]       cmd_len,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  input  logic                       status_done,
  input  logic                       status_match,
  output logic [TAG_WIDTH-1:0]       res_tag,
  output logic                       res_match,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(DEPTH):0]     cmd_count,
  output logic [$clog2(DEPTH):0]     res_count,
  output logic [31:0]                done_count,
  output logic                       error,
  input  logic                       error_ack
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int CMD_W = PMEM_ADDR_WIDTH + LEN_WIDTH + TAG_WIDTH;
  localparam int RES_W = TAG_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state_reg;

  // Storage arrays (no reset; only pointers define validity)
  logic [CMD_W-1:0] cmd_mem [DEPTH];
  logic [RES_W-1:0] res_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [CW-1:0] cmd_wr_ptr_reg, cmd_rd_ptr_reg, cmd_vis_ptr_reg;
  logic [CW-1:0] res_wr_ptr_reg, res_rd_ptr_reg;

  logic                       cmd_valid_reg;
  logic [PMEM_ADDR_WIDTH-1:0] cmd_addr_reg;
  logic [LEN_WIDTH-1:0]       cmd_len_reg;
  logic [TAG_WIDTH-1:0]       tag_reg;
  logic [31:0]                done_count_reg;
  logic                       error_reg;

  logic [PMEM_ADDR_WIDTH-1:0] head_addr;
  logic [LEN_WIDTH-1:0]       head_len;
  logic [TAG_WIDTH-1:0]       head_tag;
  logic                       cmd_push, res_push, res_pop;
  logic                       head_visible, res_free, can_pop, pop_zero, pop_issue;
  logic                       err_event;
  logic [RES_W-1:0]           res_push_data;

  assign cmd_count = cmd_wr_ptr_reg - cmd_rd_ptr_reg;
  assign res_count = res_wr_ptr_reg - res_rd_ptr_reg;
  assign in_ready  = (cmd_count != DEPTH_C);
  assign res_valid = (res_count != '0);

  assign {head_addr, head_len, head_tag} = cmd_mem[cmd_rd_ptr_reg[PW-1:0]];
  assign {res_tag, res_match}            = res_mem[res_rd_ptr_reg[PW-1:0]];

  // cmd_vis_ptr_reg trails the write pointer by one cycle, so an entry written
  // on edge N becomes eligible for issue only on edge N+2.
  assign head_visible = (cmd_vis_ptr_reg != cmd_rd_ptr_reg);
  assign res_free     = (res_count != DEPTH_C);
  assign can_pop      = (state_reg == IDLE) && head_visible && res_free;
  assign pop_zero     = can_pop && (head_len == '0);
  assign pop_issue    = can_pop && (head_len != '0);

  assign cmd_push  = in_valid && in_ready;
  assign res_pop   = res_valid && res_ready;
  // Zero-length completion and engine completion are mutually exclusive by
  // state, and the issue check reserved the slot used by the engine result.
  assign res_push  = pop_zero || ((state_reg == WAIT) && status_done);
  assign res_push_data = pop_zero ? {head_tag, 1'b0} : {tag_reg, status_match};
  assign err_event = status_done && (state_reg != WAIT);

  assign cmd_valid  = cmd_valid_reg;
  assign cmd_addr   = cmd_addr_reg;
  assign cmd_len    = cmd_len_reg;
  assign done_count = done_count_reg;
  assign error      = error_reg;

  // Data path: storage and issue latch, no reset needed
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_ptr_reg[PW-1:0]] <= {in_addr, in_len, in_tag};
    end
    if (res_push) begin
      res_mem[res_wr_ptr_reg[PW-1:0]] <= res_push_data;
    end
    if (pop_issue) begin
      cmd_addr_reg <= head_addr;
      cmd_len_reg  <= head_len;
      tag_reg      <= head_tag;
    end
  end

  // Control path: pointers, FSM, counters, error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cmd_wr_ptr_reg  <= '0;
      cmd_rd_ptr_reg  <= '0;
      cmd_vis_ptr_reg <= '0;
      res_wr_ptr_reg  <= '0;
      res_rd_ptr_reg  <= '0;
      cmd_valid_reg   <= 1'b0;
      done_count_reg  <= '0;
      error_reg       <= 1'b0;
    end else begin
      cmd_vis_ptr_reg <= cmd_wr_ptr_reg;
      if (cmd_push) cmd_wr_ptr_reg <= cmd_wr_ptr_reg + 1'b1;
      if (can_pop)  cmd_rd_ptr_reg <= cmd_rd_ptr_reg + 1'b1;
      if (res_push) begin
        res_wr_ptr_reg <= res_wr_ptr_reg + 1'b1;
        done_count_reg <= done_count_reg + 32'd1;
      end
      if (res_pop) res_rd_ptr_reg <= res_rd_ptr_reg + 1'b1;

      // A new stray completion takes priority over the acknowledge
      if (err_event)      error_reg <= 1'b1;
      else if (error_ack) error_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (pop_issue) begin
            state_reg     <= ISSUE;
            cmd_valid_reg <= 1'b1;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            state_reg     <= WAIT;
            cmd_valid_reg <= 1'b0;
          end
        end
        WAIT: begin
          if (status_done) state_reg <= IDLE;
        end
        default: begin
          state_reg     <= IDLE;
          cmd_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
